// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM responder model: command and init-state
// encodings, default timing constants and a CAS-latency legality helper.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        ST_WAIT_PRE,
        ST_WAIT_REF,
        ST_WAIT_LMR,
        ST_READY
    } init_e;

    localparam logic [2:0] CAS_DEF  = 3'd2;
    localparam int         TRCD_DEF = 3;

    function automatic logic cas_valid(input logic [2:0] c);
        return (c == 3'd2) || (c == 3'd3);
    endfunction

endpackage

// File: rtl/sdram_resp_if.sv
// SDRAM command/address bundle; the controller side drives it, the memory
// side samples it. The data bus is bidirectional and lives outside this bundle.
interface sdram_resp_if;
    logic        cke;
    logic        csn;
    logic        rasn;
    logic        casn;
    logic        wen;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dqm;

    modport master (output cke, csn, rasn, casn, wen, ba, addr, dqm);
    modport slave  (input  cke, csn, rasn, casn, wen, ba, addr, dqm);
endinterface

// File: rtl/sdram_resp_bank.sv
// Per-bank state: open flag, open row and the ACTIVE-to-READ/WRITE counter.
module sdram_resp_bank
    import sdram_pkg::*;
#(
    parameter int TRCD_CYC = TRCD_DEF
) (
    input  logic       r_clk,
    input  logic       rst_n,
    input  logic       act,
    input  logic       pre,
    input  logic [1:0] row_in,
    output logic       bank_open,
    output logic       rcd_ok,
    output logic [1:0] row
);

    // Loaded with TRCD_CYC-1 so the command exactly TRCD_CYC edges later sees zero.
    localparam logic [3:0] RCD_LOAD = (TRCD_CYC > 0) ? 4'(TRCD_CYC - 1) : '0;

    logic [3:0] rcd_cnt;

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_open <= 1'b0;
            row       <= '0;
            rcd_cnt   <= '0;
        end else if (act) begin
            bank_open <= 1'b1;
            row       <= row_in;
            rcd_cnt   <= RCD_LOAD;
        end else begin
            if (pre)
                bank_open <= 1'b0;
            if (rcd_cnt != '0)
                rcd_cnt <= rcd_cnt - 4'd1;
        end
    end

    assign rcd_ok = (rcd_cnt == '0);

endmodule

// File: rtl/sdram_resp.sv
// Behavioural SDRAM responder: decodes commands, tracks init and bank state,
// stores writes and returns read data after the programmed CAS latency.
module sdram_resp
    import sdram_pkg::*;
#(
    parameter logic [2:0] CAS      = CAS_DEF,
    parameter int         TRCD_CYC = TRCD_DEF,
    parameter int         MEM_AW   = 12
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        sdram_cke,
    input  logic        sdram_csn,
    input  logic        sdram_rasn,
    input  logic        sdram_casn,
    input  logic        sdram_wen,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_addr,
    input  logic [1:0]  sdram_dqm,
    inout  wire  [15:0] sdram_data,
    output logic        o_init_done,
    output logic        o_err,
    output logic [2:0]  o_cas
);

    cmd_e        cmd;
    init_e       state_q, state_d;
    logic        ref_seen_q, ref_seen_d;
    logic        ready;
    logic        lmr_bad, act_err, ref_err, rw_err;
    logic        act_ok, rd_ok, wr_ok;
    logic [3:0]  bank_open, rcd_ok;
    logic [1:0]  bank_row [4];
    logic [MEM_AW-1:0] idx;
    logic [15:0] mem [2**MEM_AW];
    logic [2:0]  rd_v, rd_f;
    logic [15:0] rd_d [3];
    logic [1:0]  sel;
    logic        drive;
    logic        unused_addr;

    assign cmd   = (sdram_cke && !sdram_csn) ? cmd_e'({sdram_rasn, sdram_casn, sdram_wen}) : CMD_NOP;
    assign ready = (state_q == ST_READY);
    assign o_init_done = ready;
    assign unused_addr = ^{sdram_addr[12:11], sdram_addr[9:8]};

    assign lmr_bad = (cmd == CMD_LMR) && (!cas_valid(sdram_addr[6:4]) || (sdram_addr[2:0] != 3'b000));
    assign act_err = (cmd == CMD_ACT) && (!ready || bank_open[sdram_ba]);
    assign ref_err = (cmd == CMD_REF) && (|bank_open);
    assign rw_err  = ((cmd == CMD_RD) || (cmd == CMD_WR)) &&
                     (!ready || !bank_open[sdram_ba] || !rcd_ok[sdram_ba]);
    assign act_ok  = (cmd == CMD_ACT) && !act_err;
    assign rd_ok   = (cmd == CMD_RD) && !rw_err;
    // A write landing in an active read slot would sample our own drive; drop it.
    assign wr_ok   = (cmd == CMD_WR) && !rw_err && !drive;

    for (genvar g = 0; g < 4; g++) begin : g_bank
        sdram_resp_bank #(.TRCD_CYC(TRCD_CYC)) u_bank (
            .r_clk     (i_clk),
            .rst_n     (i_rstn),
            .act       (act_ok && (sdram_ba == 2'(g))),
            .pre       ((cmd == CMD_PRE) && (sdram_addr[10] || (sdram_ba == 2'(g)))),
            .row_in    (sdram_addr[1:0]),
            .bank_open (bank_open[g]),
            .rcd_ok    (rcd_ok[g]),
            .row       (bank_row[g])
        );
    end

    always_comb begin
        state_d    = state_q;
        ref_seen_d = ref_seen_q;
        unique case (state_q)
            ST_WAIT_PRE: if (cmd == CMD_PRE && sdram_addr[10]) state_d = ST_WAIT_REF;
            ST_WAIT_REF: if (cmd == CMD_REF) begin
                if (ref_seen_q) begin
                    state_d    = ST_WAIT_LMR;
                    ref_seen_d = 1'b0;
                end else begin
                    ref_seen_d = 1'b1;
                end
            end
            ST_WAIT_LMR: if (cmd == CMD_LMR && !lmr_bad) state_d = ST_READY;
            ST_READY:    state_d = ST_READY;
            default:     state_d = ST_WAIT_PRE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_WAIT_PRE;
            ref_seen_q <= 1'b0;
            o_err      <= 1'b0;
            o_cas      <= CAS;
            rd_v       <= '0;
            rd_f       <= '0;
        end else begin
            state_q    <= state_d;
            ref_seen_q <= ref_seen_d;
            o_err      <= o_err | lmr_bad | act_err | ref_err | rw_err;
            if (cmd == CMD_LMR && !lmr_bad)
                o_cas <= sdram_addr[6:4];
            rd_v <= {rd_v[1:0], rd_ok};
            rd_f <= {rd_f[1:0], &sdram_dqm};
        end
    end

    assign idx = MEM_AW'({sdram_ba, bank_row[sdram_ba], sdram_addr[7:0]});

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            if (!sdram_dqm[0]) mem[idx][7:0]  <= sdram_data[7:0];
            if (!sdram_dqm[1]) mem[idx][15:8] <= sdram_data[15:8];
        end
        rd_d[0] <= mem[idx];
        for (int unsigned i = 1; i < 3; i++)
            rd_d[i] <= rd_d[i-1];
    end

    // Stage n is loaded n edges after the READ, so stage CL-1 owns the bus slot.
    assign sel   = (o_cas == 3'd3) ? 2'd2 : (o_cas == 3'd2) ? 2'd1 : 2'd0;
    assign drive = rd_v[sel] && !rd_f[sel];
    assign sdram_data = drive ? rd_d[sel] : 'z;

endmodule

// File: tb/tb_sdram_resp.sv
// Directed bench for sdram_resp: init, write/read with CL2 and CL3, byte
// masks, protocol errors and reset during an in-flight read.
module tb_sdram_resp;
    import sdram_pkg::*;

    logic        clk;
    logic        rstn;
    logic        tb_oe;
    logic [15:0] tb_dq;
    tri1  [15:0] dq;
    logic        init_done;
    logic        err;
    logic [2:0]  cas;
    int          n_checks;
    int          n_err;

    sdram_resp_if bus ();

    assign dq = tb_oe ? tb_dq : 'z;

    sdram_resp #(.CAS(3'd2), .TRCD_CYC(3), .MEM_AW(12)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .sdram_cke   (bus.cke),
        .sdram_csn   (bus.csn),
        .sdram_rasn  (bus.rasn),
        .sdram_casn  (bus.casn),
        .sdram_wen   (bus.wen),
        .sdram_ba    (bus.ba),
        .sdram_addr  (bus.addr),
        .sdram_dqm   (bus.dqm),
        .sdram_data  (dq),
        .o_init_done (init_done),
        .o_err       (err),
        .o_cas       (cas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input cmd_e c, input logic [1:0] b, input logic [12:0] a, input logic [1:0] m);
        bus.csn = 1'b0;
        {bus.rasn, bus.casn, bus.wen} = c;
        bus.ba   = b;
        bus.addr = a;
        bus.dqm  = m;
        step();
        bus.csn = 1'b1;
        {bus.rasn, bus.casn, bus.wen} = 3'b111;
        bus.dqm = 2'b00;
        tb_oe   = 1'b0;
    endtask

    task automatic write(input logic [1:0] b, input logic [12:0] a, input logic [15:0] d, input logic [1:0] m);
        tb_oe = 1'b1;
        tb_dq = d;
        issue(CMD_WR, b, a, m);
    endtask

    task automatic init_seq();
        issue(CMD_PRE, 2'd0, 13'h0400, 2'b00);
        issue(CMD_REF, 2'd0, 13'h0000, 2'b00);
        issue(CMD_REF, 2'd0, 13'h0000, 2'b00);
        issue(CMD_LMR, 2'd0, 13'h0020, 2'b00);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        bus.cke  = 1'b1;
        bus.csn  = 1'b1;
        {bus.rasn, bus.casn, bus.wen} = 3'b111;
        bus.ba   = 2'd0;
        bus.addr = '0;
        bus.dqm  = 2'b00;
        tb_oe    = 1'b0;
        tb_dq    = '0;
        rstn     = 1'b0;
        repeat (3) step();
        check("rst_init_done", {15'd0, init_done}, 16'h0000);
        check("rst_err",       {15'd0, err},       16'h0000);
        check("rst_cas",       {13'd0, cas},       16'h0002);
        check("rst_bus",       dq,                 16'hFFFF);
        rstn = 1'b1;
        step();

        // Power-up sequence
        issue(CMD_PRE, 2'd0, 13'h0400, 2'b00);
        check("pre_not_ready", {15'd0, init_done}, 16'h0000);
        issue(CMD_REF, 2'd0, 13'h0000, 2'b00);
        issue(CMD_REF, 2'd0, 13'h0000, 2'b00);
        check("ref_not_ready", {15'd0, init_done}, 16'h0000);
        issue(CMD_LMR, 2'd0, 13'h0020, 2'b00);
        check("init_done", {15'd0, init_done}, 16'h0001);
        check("init_cas",  {13'd0, cas},       16'h0002);
        check("init_err",  {15'd0, err},       16'h0000);

        // CL2 write then read
        issue(CMD_ACT, 2'd0, 13'h0000, 2'b00);
        repeat (3) step();
        write(2'd0, 13'h0000, 16'hBEEF, 2'b00);
        issue(CMD_RD, 2'd0, 13'h0000, 2'b00);
        check("cl2_k",   dq, 16'hFFFF);
        step();
        check("cl2_k1",  dq, 16'hBEEF);
        step();
        check("cl2_k2",  dq, 16'hFFFF);
        check("cl2_err", {15'd0, err}, 16'h0000);

        // CL3 with upper byte masked on the second write
        issue(CMD_LMR, 2'd0, 13'h0030, 2'b00);
        check("lmr_cas3", {13'd0, cas}, 16'h0003);
        write(2'd0, 13'h0005, 16'h1234, 2'b00);
        write(2'd0, 13'h0005, 16'hABCD, 2'b10);
        issue(CMD_RD, 2'd0, 13'h0005, 2'b00);
        step();
        check("cl3_k1", dq, 16'hFFFF);
        step();
        check("cl3_k2", dq, 16'h12CD);
        step();
        check("cl3_k3", dq, 16'hFFFF);

        // Back-to-back reads return consecutive words
        issue(CMD_RD, 2'd0, 13'h0000, 2'b00);
        issue(CMD_RD, 2'd0, 13'h0005, 2'b00);
        step();
        check("b2b_first",  dq, 16'hBEEF);
        step();
        check("b2b_second", dq, 16'h12CD);
        step();
        check("b2b_after",  dq, 16'hFFFF);

        // Fully masked read leaves the bus floating
        issue(CMD_RD, 2'd0, 13'h0000, 2'b11);
        step();
        step();
        check("rd_masked", dq, 16'hFFFF);
        check("clean_err", {15'd0, err}, 16'h0000);

        // Read to a closed bank
        issue(CMD_RD, 2'd1, 13'h0000, 2'b00);
        check("closed_err", {15'd0, err}, 16'h0001);
        step();
        step();
        check("closed_bus", dq, 16'hFFFF);
        issue(CMD_RD, 2'd0, 13'h0000, 2'b00);
        check("err_sticky", {15'd0, err}, 16'h0001);
        step();
        step();
        check("rd_after_err", dq, 16'hBEEF);

        // Asynchronous reset clears control state immediately
        rstn = 1'b0;
        #1;
        check("arst_err",  {15'd0, err},       16'h0000);
        check("arst_cas",  {13'd0, cas},       16'h0002);
        check("arst_done", {15'd0, init_done}, 16'h0000);
        repeat (2) step();
        rstn = 1'b1;
        step();
        init_seq();
        check("reinit_done", {15'd0, init_done}, 16'h0001);

        // tRCD boundary: exactly TRCD_CYC edges is legal, one edge is not
        issue(CMD_ACT, 2'd2, 13'h0001, 2'b00);
        repeat (2) step();
        issue(CMD_RD, 2'd2, 13'h0000, 2'b00);
        check("trcd_exact", {15'd0, err}, 16'h0000);
        issue(CMD_ACT, 2'd3, 13'h0000, 2'b00);
        issue(CMD_RD, 2'd3, 13'h0000, 2'b00);
        check("trcd_short", {15'd0, err}, 16'h0001);

        // Storage survives reset; reset during an in-flight read
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        step();
        init_seq();
        issue(CMD_ACT, 2'd0, 13'h0000, 2'b00);
        repeat (3) step();
        issue(CMD_RD, 2'd0, 13'h0000, 2'b00);
        step();
        check("retained", dq, 16'hBEEF);
        step();
        issue(CMD_RD, 2'd0, 13'h0000, 2'b00);
        check("inflight_k", dq, 16'hFFFF);
        #3;
        rstn = 1'b0;
        #1;
        check("inflight_rst_bus",  dq,                 16'hFFFF);
        check("inflight_rst_done", {15'd0, init_done}, 16'h0000);
        step();
        check("inflight_k1", dq, 16'hFFFF);
        step();
        check("inflight_k2", dq, 16'hFFFF);
        rstn = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
